// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-coding constants and types used by the bit packer.
package jpeg_pkg;

  localparam int CODE_W_DEF = 23;
  localparam int LEN_W_DEF  = 5;
  localparam int ACC_W_DEF  = 32;

  localparam logic [7:0] JPEG_STUFF_TRIG = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE = 8'h00;
  localparam logic       JPEG_PAD_BIT    = 1'b1;

  typedef enum logic [1:0] {RUN, STUFF, FLUSH, DONE} packer_state_t;

endpackage

// File: rtl/huff_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into a JPEG byte stream,
// stuffing 0x00 after each 0xFF and padding the final byte with 1s on flush.
module huff_bit_packer
  import jpeg_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              code_vld_i,
  output logic              code_rdy_o,
  input  logic [LEN_W-1:0]  code_len_i,
  input  logic [CODE_W-1:0] code_seq_i,
  input  logic              flush_i,
  output logic [7:0]        byte_o,
  output logic              byte_vld_o,
  input  logic              byte_rdy_i,
  output logic              flush_done_o
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  packer_state_t    state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;

  logic             slot_free;
  logic             emit;
  logic             stuff_hit;
  logic             accept;
  logic [7:0]       head;
  logic [LEN_W-1:0] len_eff;
  logic [CODE_W-1:0] seq_mask;
  logic [ACC_W-1:0] seq_ext;
  logic [ACC_W-1:0] acc_sh;
  logic [ACC_W-1:0] acc_ins;
  logic [ACC_W-1:0] acc_pad;
  logic [ACC_W-1:0] pad_mask;
  logic [CNT_W-1:0] cnt_sh;
  logic [CNT_W-1:0] cnt_ins;
  logic [CNT_W-1:0] cnt_pad;
  logic [CNT_W-1:0] pad_n;
  logic [CNT_W-1:0] ins_pos;

  assign code_rdy_o = (state == RUN) && !flush_pend && (cnt <= CNT_W'(ACC_W - CODE_W));
  assign slot_free  = !byte_vld_o || byte_rdy_i;
  assign head       = acc[ACC_W-1 -: 8];
  assign emit       = ((state == RUN) || (state == FLUSH)) && (cnt >= CNT_W'(8)) && slot_free;
  assign stuff_hit  = emit && (head == JPEG_STUFF_TRIG);
  assign accept     = code_vld_i && code_rdy_o && (code_len_i != '0);

  // Pad always works on the post-emit view so a byte leaving this cycle is never padded.
  always_comb begin
    acc_sh   = emit ? (acc << 8) : acc;
    cnt_sh   = emit ? (cnt - CNT_W'(8)) : cnt;
    len_eff  = (code_len_i > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : code_len_i;
    seq_mask = code_seq_i & ~({CODE_W{1'b1}} << len_eff);
    seq_ext  = ACC_W'(seq_mask);
    ins_pos  = CNT_W'(ACC_W) - cnt_sh - CNT_W'(len_eff);
    acc_ins  = acc_sh | (seq_ext << ins_pos);
    cnt_ins  = cnt_sh + CNT_W'(len_eff);
    pad_n    = (cnt_sh[2:0] == 3'd0) ? '0 : (CNT_W'(8) - CNT_W'(cnt_sh[2:0]));
    pad_mask = ({ACC_W{1'b1}} >> cnt_sh) ^ ({ACC_W{1'b1}} >> (cnt_sh + pad_n));
    acc_pad  = JPEG_PAD_BIT ? (acc_sh | pad_mask) : (acc_sh & ~pad_mask);
    cnt_pad  = cnt_sh + pad_n;
  end

  // Re-padding on STUFF->FLUSH is harmless: once padded, cnt is byte aligned and pad_n is 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      acc          <= '0;
      cnt          <= '0;
      flush_pend   <= 1'b0;
      byte_o       <= 8'h00;
      byte_vld_o   <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      if (emit) begin
        byte_o     <= head;
        byte_vld_o <= 1'b1;
      end else if (slot_free) begin
        byte_vld_o <= 1'b0;
      end

      case (state)
        RUN: begin
          if (flush_pend) begin
            if (stuff_hit) begin
              state <= STUFF;
              acc   <= acc_sh;
              cnt   <= cnt_sh;
            end else begin
              state <= FLUSH;
              acc   <= acc_pad;
              cnt   <= cnt_pad;
            end
          end else begin
            acc <= accept ? acc_ins : acc_sh;
            cnt <= accept ? cnt_ins : cnt_sh;
            if (flush_i) flush_pend <= 1'b1;
            if (stuff_hit) state <= STUFF;
          end
        end
        STUFF: begin
          if (slot_free) begin
            byte_o     <= JPEG_STUFF_BYTE;
            byte_vld_o <= 1'b1;
            if (flush_pend) begin
              state <= FLUSH;
              acc   <= acc_pad;
              cnt   <= cnt_pad;
            end else begin
              state <= RUN;
            end
          end
        end
        FLUSH: begin
          acc <= acc_sh;
          cnt <= cnt_sh;
          if (stuff_hit) begin
            state <= STUFF;
          end else if ((cnt == '0) && slot_free) begin
            state        <= DONE;
            flush_done_o <= 1'b1;
          end
        end
        DONE: begin
          flush_pend <= 1'b0;
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Directed bench for huff_bit_packer: vector table plus hand-written stall/reset sequences.
module tb_huff_bit_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        code_vld_i;
  logic        code_rdy_o;
  logic [4:0]  code_len_i;
  logic [22:0] code_seq_i;
  logic        flush_i;
  logic [7:0]  byte_o;
  logic        byte_vld_o;
  logic        byte_rdy_i;
  logic        flush_done_o;

  huff_bit_packer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .code_vld_i   (code_vld_i),
    .code_rdy_o   (code_rdy_o),
    .code_len_i   (code_len_i),
    .code_seq_i   (code_seq_i),
    .flush_i      (flush_i),
    .byte_o       (byte_o),
    .byte_vld_o   (byte_vld_o),
    .byte_rdy_i   (byte_rdy_i),
    .flush_done_o (flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int                ncodes;
    logic [0:3][4:0]   len;
    logic [0:3][22:0]  seq;
    logic              flush;
    int                nexp;
    logic [0:15][7:0]  exp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  logic [7:0] got[$];
  int doneCount = 0;
  int nChecks = 0;
  int nFails = 0;

  // Handoffs are observed mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (byte_vld_o && byte_rdy_i) got.push_back(byte_o);
      if (flush_done_o) doneCount++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic sendCode(input logic [4:0] l, input logic [22:0] s);
    int t = 0;
    code_vld_i = 1'b1;
    code_len_i = l;
    code_seq_i = s;
    while (!code_rdy_o && t < 60) begin
      tick(1);
      t++;
    end
    if (t >= 60) checkOutput("code handshake timeout", 0, 1);
    tick(1);
    code_vld_i = 1'b0;
    code_len_i = '0;
    code_seq_i = '0;
  endtask

  task automatic doFlush();
    int t = 0;
    while (!code_rdy_o && t < 60) begin
      tick(1);
      t++;
    end
    if (t >= 60) checkOutput("flush ready timeout", 0, 1);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  task automatic waitDone();
    int t = 0;
    while (doneCount == 0 && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) checkOutput("flush_done timeout", 0, 1);
    tick(5);
  endtask

  task automatic applyStimulus(input int v);
    for (int c = 0; c < vecs[v].ncodes; c++) sendCode(vecs[v].len[c], vecs[v].seq[c]);
    if (vecs[v].flush) begin
      doFlush();
      waitDone();
    end else begin
      tick(20);
    end
  endtask

  task automatic pulseReset();
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
  endtask

  function automatic void addCode(input int v, input logic [4:0] l, input logic [22:0] s);
    vecs[v].len[vecs[v].ncodes] = l;
    vecs[v].seq[vecs[v].ncodes] = s;
    vecs[v].ncodes++;
  endfunction

  function automatic void addExp(input int v, input logic [7:0] b);
    vecs[v].exp[vecs[v].nexp] = b;
    vecs[v].nexp++;
  endfunction

  function automatic void buildVectors();
    logic [7:0] v6[16] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFE, 8'hAA, 8'hAA, 8'hAB,
                           8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFA, 8'hAA, 8'hAA, 8'hAF};
    for (int v = 0; v < NV; v++) vecs[v] = '0;
    addCode(0, 5'd8, 23'h0000D6);  vecs[0].flush = 1'b1; addExp(0, 8'hD6);
    addCode(1, 5'd8, 23'h0000FF);  addExp(1, 8'hFF); addExp(1, 8'h00);
    addCode(2, 5'd4, 23'h00000F);  addCode(2, 5'd4, 23'h00000F);
    addExp(2, 8'hFF); addExp(2, 8'h00);
    addCode(3, 5'd3, 23'h000005);  vecs[3].flush = 1'b1; addExp(3, 8'hBF);
    addCode(4, 5'd0, 23'h7FFFFF);  vecs[4].flush = 1'b1;
    addCode(5, 5'd4, 23'h7FFFF5);  addCode(5, 5'd4, 23'h000003); addExp(5, 8'h53);
    addCode(6, 5'd23, 23'h7FFFFF); addCode(6, 5'd23, 23'h2AAAAA);
    addCode(6, 5'd23, 23'h7FFFFF); addCode(6, 5'd23, 23'h2AAAAA);
    vecs[6].flush = 1'b1;
    for (int i = 0; i < 16; i++) addExp(6, v6[i]);
  endfunction

  function automatic int gotAt(input int i);
    return (i < got.size()) ? int'(got[i]) : -1;
  endfunction

  initial begin
    rst_i      = 1'b1;
    code_vld_i = 1'b0;
    code_len_i = '0;
    code_seq_i = '0;
    flush_i    = 1'b0;
    byte_rdy_i = 1'b1;
    buildVectors();
    tick(3);
    rst_i = 1'b0;

    checkOutput("reset byte_vld_o", byte_vld_o, 0);
    checkOutput("reset byte_o", byte_o, 8'h00);
    checkOutput("reset flush_done_o", flush_done_o, 0);
    checkOutput("reset code_rdy_o", code_rdy_o, 1);

    for (int v = 0; v < NV; v++) begin
      got.delete();
      doneCount = 0;
      applyStimulus(v);
      checkOutput($sformatf("vec%0d byte count", v), got.size(), vecs[v].nexp);
      for (int i = 0; i < vecs[v].nexp; i++)
        checkOutput($sformatf("vec%0d byte%0d", v, i), gotAt(i), int'(vecs[v].exp[i]));
      checkOutput($sformatf("vec%0d done pulses", v), doneCount, vecs[v].flush ? 1 : 0);
    end

    // Ready must drop while more than 9 bits are held.
    got.delete();
    doneCount = 0;
    sendCode(5'd23, 23'h2AAAAA);
    checkOutput("rdy at cnt 23", code_rdy_o, 0);
    tick(1);
    checkOutput("rdy at cnt 15", code_rdy_o, 0);
    tick(1);
    checkOutput("rdy at cnt 7", code_rdy_o, 1);
    doFlush();
    waitDone();
    checkOutput("rdy seq count", got.size(), 3);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("rdy seq byte%0d", i), gotAt(i), 8'h55);

    // Backpressure holds the presented byte.
    got.delete();
    byte_rdy_i = 1'b0;
    sendCode(5'd16, 23'h001234);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput($sformatf("stall vld c%0d", i), byte_vld_o, 1);
      checkOutput($sformatf("stall byte c%0d", i), byte_o, 8'h12);
    end
    byte_rdy_i = 1'b1;
    tick(10);
    checkOutput("stall count", got.size(), 2);
    checkOutput("stall byte0", gotAt(0), 8'h12);
    checkOutput("stall byte1", gotAt(1), 8'h34);

    // Reset while parked in STUFF.
    byte_rdy_i = 1'b0;
    sendCode(5'd8, 23'h0000FF);
    tick(2);
    checkOutput("pre-reset byte_o", byte_o, 8'hFF);
    pulseReset();
    checkOutput("stuff reset vld", byte_vld_o, 0);
    checkOutput("stuff reset rdy", code_rdy_o, 1);
    checkOutput("stuff reset byte_o", byte_o, 8'h00);

    // Reset while parked in FLUSH.
    sendCode(5'd16, 23'h00ABCD);
    doFlush();
    tick(3);
    checkOutput("mid-flush rdy", code_rdy_o, 0);
    pulseReset();
    checkOutput("flush reset vld", byte_vld_o, 0);
    checkOutput("flush reset done", flush_done_o, 0);
    checkOutput("flush reset rdy", code_rdy_o, 1);
    byte_rdy_i = 1'b1;
    got.delete();
    doneCount = 0;
    sendCode(5'd8, 23'h000012);
    tick(10);
    checkOutput("post-reset count", got.size(), 1);
    checkOutput("post-reset byte0", gotAt(0), 8'h12);
    checkOutput("post-reset done", doneCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
